// File: rtl/arm_pkg.sv
// Shared types, default parameters and helpers for the ARM memory stage.
package arm_pkg;

   localparam int          DEF_WAIT_CYCLES = 2;
   localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
   localparam int          DEF_SRAM_AW     = 18;

   // Phases of one word access on the 16-bit SRAM.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_DONE
   } sram_state_t;

   // Word index of an ARM byte address relative to the SRAM window base.
   function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                              input logic [31:0] base);
      return (byte_addr - base) >> 2;
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Splits one 32-bit LDR/STR into two half-word SRAM transfers with wait states.
module sram_ctrl
   import arm_pkg::*;
#(
   parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          SRAM_AW     = DEF_SRAM_AW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_read_in,
   input  logic               mem_write_in,
   input  logic [31:0]        addr_in,
   input  logic [31:0]        wdata_in,
   output logic               ready,
   output logic               done,
   output logic               is_read,
   output logic [31:0]        rdata,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_wdata,
   input  logic [15:0]        sram_rdata,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

   sram_state_t        state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [SRAM_AW-2:0] wa_q, wa_d;
   logic [31:0]        wval_q, wval_d;
   logic               rd_q, rd_d;
   logic [31:0]        data_q, data_d;
   logic               hi_sel;
   logic               req;

   assign req       = mem_read_in | mem_write_in;
   assign done      = (state_q == ST_DONE);
   assign is_read   = rd_q;
   assign rdata     = data_q;
   assign sram_addr = {wa_q, hi_sel};

   // Next-state, wait counting, bus drive and read-data assembly.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      cnt_d      = cnt_q;
      wa_d       = wa_q;
      wval_d     = wval_q;
      rd_d       = rd_q;
      data_d     = data_q;
      ready      = 1'b0;
      hi_sel     = 1'b0;
      sram_we_n  = 1'b1;
      sram_oe_n  = 1'b1;
      sram_wdata = 16'h0000;
      case (state_q)
         ST_IDLE: begin
            // Ready drops in the same cycle the request shows up so upstream freezes at once.
            ready = ~req;
            if (req) begin
               state_d = ST_LO;
               cnt_d   = '0;
               wa_d    = (SRAM_AW-1)'(word_index(addr_in, BASE_ADDR));
               wval_d  = wdata_in;
               rd_d    = mem_read_in;   // read wins if both are set
            end
         end
         ST_LO: begin
            sram_we_n  = rd_q;
            sram_oe_n  = ~rd_q;
            sram_wdata = wval_q[15:0];
            if (cnt_q == LAST) begin
               if (rd_q) data_d[15:0] = sram_rdata;
               cnt_d   = '0;
               state_d = ST_HI;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HI: begin
            hi_sel     = 1'b1;
            sram_we_n  = rd_q;
            sram_oe_n  = ~rd_q;
            sram_wdata = wval_q[31:16];
            if (cnt_q == LAST) begin
               if (rd_q) data_d[31:16] = sram_rdata;
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            // The frozen request is still on the inputs here; it is not restarted.
            ready   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Controller state; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wa_q    <= '0;
         wval_q  <= '0;
         rd_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wa_q    <= wa_d;
         wval_q  <= wval_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// ARM MEM stage: SRAM word access controller plus the MEM/WB pipeline register.
module mem_stage
   import arm_pkg::*;
#(
   parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          SRAM_AW     = DEF_SRAM_AW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               WB_Enable_in,
   input  logic               mem_read_in,
   input  logic               mem_write_in,
   input  logic [3:0]         RD_in,
   input  logic [31:0]        ALU_result_in,
   input  logic [31:0]        Val_Rm_in,
   output logic               ready,
   output logic               WB_Enable,
   output logic               mem_read,
   output logic [3:0]         RD,
   output logic [31:0]        ALU_result,
   output logic [31:0]        mem_read_data,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_wdata,
   input  logic [15:0]        sram_rdata,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   logic        ctrl_done;
   logic        ctrl_is_read;
   logic [31:0] ctrl_rdata;

   logic        wb_enable_q, wb_enable_d;
   logic        mem_read_q, mem_read_d;
   logic [3:0]  rd_q, rd_d;
   logic [31:0] alu_result_q, alu_result_d;
   logic [31:0] mem_read_data_q, mem_read_data_d;

   sram_ctrl #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .BASE_ADDR   (BASE_ADDR),
      .SRAM_AW     (SRAM_AW)
   ) u_sram_ctrl (
      .clk          (clk),
      .rst          (rst),
      .mem_read_in  (mem_read_in),
      .mem_write_in (mem_write_in),
      .addr_in      (ALU_result_in),
      .wdata_in     (Val_Rm_in),
      .ready        (ready),
      .done         (ctrl_done),
      .is_read      (ctrl_is_read),
      .rdata        (ctrl_rdata),
      .sram_addr    (sram_addr),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata),
      .sram_we_n    (sram_we_n),
      .sram_oe_n    (sram_oe_n)
   );

   // MEM/WB next value: take the instruction when ready, otherwise insert a bubble.
   always_comb begin
      wb_enable_d     = 1'b0;
      mem_read_d      = 1'b0;
      rd_d            = rd_q;
      alu_result_d    = alu_result_q;
      mem_read_data_d = mem_read_data_q;
      if (ready) begin
         wb_enable_d     = WB_Enable_in;
         mem_read_d      = mem_read_in;
         rd_d            = RD_in;
         alu_result_d    = ALU_result_in;
         mem_read_data_d = (ctrl_done && ctrl_is_read) ? ctrl_rdata : 32'h0;
      end
   end

   // MEM/WB pipeline register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_enable_q     <= 1'b0;
         mem_read_q      <= 1'b0;
         rd_q            <= '0;
         alu_result_q    <= '0;
         mem_read_data_q <= '0;
      end else begin
         wb_enable_q     <= wb_enable_d;
         mem_read_q      <= mem_read_d;
         rd_q            <= rd_d;
         alu_result_q    <= alu_result_d;
         mem_read_data_q <= mem_read_data_d;
      end
   end

   assign WB_Enable     = wb_enable_q;
   assign mem_read      = mem_read_q;
   assign RD            = rd_q;
   assign ALU_result    = alu_result_q;
   assign mem_read_data = mem_read_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random instruction mix
// against a word-level reference memory.
module tb_mem_stage;
   import arm_pkg::*;

   localparam int          W     = DEF_WAIT_CYCLES;
   localparam int          AW    = DEF_SRAM_AW;
   localparam logic [31:0] BASE  = DEF_BASE_ADDR;
   localparam int          DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          WB_Enable_in, mem_read_in, mem_write_in;
   logic [3:0]    RD_in;
   logic [31:0]   ALU_result_in, Val_Rm_in;
   logic          ready, WB_Enable, mem_read;
   logic [3:0]    RD;
   logic [31:0]   ALU_result, mem_read_data;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_wdata, sram_rdata;
   logic          sram_we_n, sram_oe_n;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage dut (
      .clk           (clk),
      .rst           (rst),
      .WB_Enable_in  (WB_Enable_in),
      .mem_read_in   (mem_read_in),
      .mem_write_in  (mem_write_in),
      .RD_in         (RD_in),
      .ALU_result_in (ALU_result_in),
      .Val_Rm_in     (Val_Rm_in),
      .ready         (ready),
      .WB_Enable     (WB_Enable),
      .mem_read      (mem_read),
      .RD            (RD),
      .ALU_result    (ALU_result),
      .mem_read_data (mem_read_data),
      .sram_addr     (sram_addr),
      .sram_wdata    (sram_wdata),
      .sram_rdata    (sram_rdata),
      .sram_we_n     (sram_we_n),
      .sram_oe_n     (sram_oe_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] init_pat(input int a);
      return 16'(a * 7 + 32'h1234);
   endfunction

   // External SRAM device model.
   logic [15:0] sram [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) sram[i] = init_pat(i);
      forever begin
         @(posedge clk);
         if (!sram_we_n) sram[sram_addr] <= sram_wdata;
      end
   end
   assign sram_rdata = !sram_oe_n ? sram[sram_addr] : 16'h0000;

   // Reference memory: half-word contents as the program should see them.
   logic [15:0] ref_mem [int];
   function automatic logic [15:0] ref_read(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
   endfunction

   // Issue one instruction (called right after a falling edge) and check it end to end.
   task automatic run_op(input string tag, input logic wbe, input logic rd_en, input logic wr_en,
                         input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] val);
      logic [31:0] wa, lo, hi, exp_data, exp_addr, exp_wd;
      logic        is_mem, is_read, is_store;
      int          stall, we_cnt, oe_cnt, half;
      is_mem   = rd_en | wr_en;
      is_read  = rd_en;
      is_store = wr_en & ~rd_en;
      wa       = (alu - BASE) / 4;
      lo       = (wa * 2) % DEPTH;
      hi       = (wa * 2 + 1) % DEPTH;
      exp_data = is_read ? {ref_read(int'(hi)), ref_read(int'(lo))} : 32'h0;
      if (is_store) begin
         ref_mem[int'(lo)] = val[15:0];
         ref_mem[int'(hi)] = val[31:16];
      end

      WB_Enable_in  = wbe;
      mem_read_in   = rd_en;
      mem_write_in  = wr_en;
      RD_in         = rd;
      ALU_result_in = alu;
      Val_Rm_in     = val;
      #1;
      if (!is_mem) begin
         check({tag, " ready"}, {31'b0, ready}, 32'd1);
      end else begin
         stall  = 0;
         we_cnt = 0;
         oe_cnt = 0;
         while (ready == 1'b0 && stall < 50) begin
            half     = (stall - 1) / W;
            exp_addr = (half != 0) ? hi : lo;
            exp_wd   = (half != 0) ? {16'h0, val[31:16]} : {16'h0, val[15:0]};
            if (!sram_we_n) begin
               we_cnt++;
               check({tag, " wr addr"}, 32'(sram_addr), exp_addr);
               check({tag, " wr data"}, 32'(sram_wdata), exp_wd);
            end
            if (!sram_oe_n) begin
               oe_cnt++;
               check({tag, " rd addr"}, 32'(sram_addr), exp_addr);
            end
            if (stall == 1)
               check({tag, " bubble"}, {30'b0, WB_Enable, mem_read}, 32'd0);
            stall++;
            @(negedge clk);
            #1;
         end
         check({tag, " stall cycles"}, 32'(stall), 32'(1 + 2 * W));
         check({tag, " we_n cycles"}, 32'(we_cnt), is_store ? 32'(2 * W) : 32'd0);
         check({tag, " oe_n cycles"}, 32'(oe_cnt), is_read ? 32'(2 * W) : 32'd0);
         check({tag, " done strobes"}, {30'b0, sram_we_n, sram_oe_n}, 32'd3);
      end
      @(negedge clk);
      #1;
      check({tag, " WB_Enable"}, {31'b0, WB_Enable}, {31'b0, wbe});
      check({tag, " mem_read"}, {31'b0, mem_read}, {31'b0, rd_en});
      check({tag, " RD"}, {28'b0, RD}, {28'b0, rd});
      check({tag, " ALU_result"}, ALU_result, alu);
      check({tag, " mem_read_data"}, mem_read_data, exp_data);
   endtask

   task automatic idle_inputs();
      WB_Enable_in  = 1'b0;
      mem_read_in   = 1'b0;
      mem_write_in  = 1'b0;
      RD_in         = 4'h0;
      ALU_result_in = 32'h0;
      Val_Rm_in     = 32'h0;
   endtask

   initial begin
      logic [31:0] alu, val;
      int          kind;
      rst = 1'b0;
      idle_inputs();
      #12;
      check("reset outputs", {WB_Enable, mem_read, RD, 26'b0}, 32'h0);
      check("reset ALU_result", ALU_result, 32'h0);
      check("reset mem_read_data", mem_read_data, 32'h0);
      check("reset strobes", {30'b0, sram_we_n, sram_oe_n}, 32'd3);
      check("reset sram bus", {14'b0, sram_addr} | {16'b0, sram_wdata}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("idle ready", {31'b0, ready}, 32'd1);

      // Directed cases.
      run_op("add", 1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'h0);
      run_op("str", 1'b0, 1'b0, 1'b1, 4'd0, BASE, 32'hDEADBEEF);
      run_op("ldr", 1'b1, 1'b1, 1'b0, 4'd5, BASE, 32'h0);
      run_op("ldr1028", 1'b1, 1'b1, 1'b0, 4'd6, BASE + 32'd4, 32'h0);
      run_op("add2", 1'b1, 1'b0, 1'b0, 4'd7, 32'h1234_5678, 32'h0);
      run_op("ldr wrap", 1'b1, 1'b1, 1'b0, 4'd8, BASE + 32'd4 * (32'd1 << 17), 32'h0);
      run_op("rd+wr", 1'b1, 1'b1, 1'b1, 4'd9, BASE + 32'd4, 32'hCAFEF00D);

      // Reset while the high half of a load is on the bus.
      WB_Enable_in  = 1'b1;
      mem_read_in   = 1'b1;
      mem_write_in  = 1'b0;
      RD_in         = 4'd10;
      ALU_result_in = BASE;
      repeat (1 + W) @(negedge clk);
      #1;
      check("pre-reset in HI", {31'b0, sram_oe_n}, 32'd0);
      check("pre-reset addr", 32'(sram_addr), 32'd1);
      rst = 1'b0;
      #1;
      check("mid reset RD", {28'b0, RD}, 32'd0);
      check("mid reset ALU_result", ALU_result, 32'h0);
      check("mid reset flags", {30'b0, WB_Enable, mem_read}, 32'd0);
      check("mid reset strobes", {30'b0, sram_we_n, sram_oe_n}, 32'd3);
      check("mid reset sram_addr", 32'(sram_addr), 32'd0);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post reset ready", {31'b0, ready}, 32'd1);
      run_op("post reset ldr", 1'b1, 1'b1, 1'b0, 4'd11, BASE, 32'h0);

      // Random instruction mix.
      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 9));
         if ($urandom_range(0, 7) == 0) alu = $urandom();
         else alu = BASE + 32'($urandom_range(0, 127));
         val = $urandom();
         case (kind)
            0, 1, 2: run_op("rnd str", 1'($urandom()), 1'b0, 1'b1, 4'($urandom()), alu, val);
            3, 4, 5: run_op("rnd ldr", 1'($urandom()), 1'b1, 1'b0, 4'($urandom()), alu, val);
            6:       run_op("rnd rd+wr", 1'($urandom()), 1'b1, 1'b1, 4'($urandom()), alu, val);
            default: run_op("rnd alu", 1'($urandom()), 1'b0, 1'b0, 4'($urandom()), val, alu);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
